// File: rtl/count_sched_pkg.sv
// Shared state encoding and parameter defaults for the count_sched block.
package count_sched_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned NREQ_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/count_sched_count_unit.sv
// Shared counter: clears to zero and captures a terminal value together,
// then counts up while enabled and flags when the terminal value is reached.
module count_unit
  import count_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_limit_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;

  // Next count/limit: clear wins over enable; otherwise hold.
  always_comb begin
    count_d = count_q;
    limit_d = limit_q;
    if (clr_i) begin
      count_d = '0;
      limit_d = limit_i;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter and limit registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      limit_q <= '0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q == limit_q);

endmodule

// File: rtl/count_sched.sv
// Two-requester round-robin scheduler driving one shared counter.
// A winner runs the counter from 0 to its latched length, gets a one-cycle
// done pulse, and the pointer then favours the other requester.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NREQ  = NREQ_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic [NREQ-1:0]  done
);

  state_e           state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  done_q;
  logic             busy_q;
  logic             win_q;
  logic             ptr_q;

  logic             win_d;
  logic             cnt_clr;
  logic             cnt_en;
  logic             at_limit;
  logic [WIDTH-1:0] limit_sel;

  // Arbitration and counter controls decoded from registered state.
  always_comb begin
    win_d     = (req[0] && req[1]) ? ptr_q : req[1];
    limit_sel = win_d ? len1 : len0;
    cnt_clr   = (state_q == IDLE) && (|req);
    cnt_en    = (state_q == RUN) && req[win_q] && !at_limit;
  end

  count_unit #(
    .WIDTH (WIDTH)
  ) u_count (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .limit_i    (limit_sel),
    .count_o    (count),
    .at_limit_o (at_limit)
  );

  // Scheduler FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= RUN;
            win_q   <= win_d;
            gnt_q   <= NREQ'(1) << win_d;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          // A dropped request aborts before the limit test so no pulse fires.
          if (!req[win_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ~win_q;
          end else if (at_limit) begin
            state_q <= DONE;
            done_q  <= gnt_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= ~win_q;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
